// File: rtl/riscv_dx_stage_mdu.sv
// rtl/riscv_dx_stage_mdu.sv - RISC-V decode/execute register, operand forwarding and iterative RV32M unit
// Define RISCV_DX_MDU_DIV_EN to add restoring division for funct3 1xx.
module riscv_dx_stage_mdu #(
  parameter int XLEN = 32,
  parameter int NUM_FWD = 2,
  parameter logic [XLEN-1:0] RESET_PC = 'h2000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    f_valid,
  input  logic [31:0]             f_inst,
  input  logic [XLEN-1:0]         f_pc,
  output logic                    f_ready,
  input  logic                    flush,
  input  logic [XLEN-1:0]         rf_rs1_data,
  input  logic [XLEN-1:0]         rf_rs2_data,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [5*NUM_FWD-1:0]    fwd_rd,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  output logic                    dx_valid,
  output logic [31:0]             dx_inst,
  output logic [XLEN-1:0]         dx_pc,
  output logic [4:0]              dx_ra,
  output logic [4:0]              dx_rb,
  output logic [XLEN-1:0]         dx_rs1_fwd,
  output logic [XLEN-1:0]         dx_rs2_fwd,
  output logic                    dx_is_md,
  output logic                    dx_md_busy,
  output logic [XLEN-1:0]         dx_md_result,
  output logic                    dx_md_illegal,
  output logic                    dx_out_valid,
  input  logic                    x_ready
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mcand;
  logic [2:0]        f3_q;
  logic              a_neg_q;
  logic              b_neg_q;

  logic [2:0]        f3_in;
  logic              a_sgn_in, b_sgn_in, a_neg_in, b_neg_in;
  logic [XLEN-1:0]   a_mag_in, b_mag_in;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, mul_fin, step_next;
  logic [XLEN-1:0]   mul_res, fin_result;

  assign dx_ra        = dx_inst[19:15];
  assign dx_rb        = dx_inst[24:20];
  assign dx_is_md     = (dx_inst[6:0] == 7'b0110011) && (dx_inst[31:25] == 7'b0000001);
  assign dx_md_busy   = (state == S_BUSY);
  assign dx_out_valid = dx_valid && (!dx_is_md || state == S_DONE);
  assign f_ready      = !dx_valid || (dx_out_valid && x_ready);

  // Walk sources oldest to youngest so the lowest matching index wins.
  always_comb begin
    dx_rs1_fwd = rf_rs1_data;
    dx_rs2_fwd = rf_rs2_data;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && fwd_rd[5*i +: 5] == dx_ra) dx_rs1_fwd = fwd_data[XLEN*i +: XLEN];
      if (fwd_valid[i] && fwd_rd[5*i +: 5] == dx_rb) dx_rs2_fwd = fwd_data[XLEN*i +: XLEN];
    end
    if (dx_ra == 5'd0) dx_rs1_fwd = '0;
    if (dx_rb == 5'd0) dx_rs2_fwd = '0;
  end

  always_comb begin
    f3_in    = dx_inst[14:12];
    a_sgn_in = f3_in[2] ? !f3_in[0] : (f3_in[1:0] == 2'b01 || f3_in[1:0] == 2'b10);
    b_sgn_in = f3_in[2] ? !f3_in[0] : (f3_in[1:0] == 2'b01);
    a_neg_in = a_sgn_in && dx_rs1_fwd[XLEN-1];
    b_neg_in = b_sgn_in && dx_rs2_fwd[XLEN-1];
    a_mag_in = a_neg_in ? -dx_rs1_fwd : dx_rs1_fwd;
    b_mag_in = b_neg_in ? -dx_rs2_fwd : dx_rs2_fwd;
  end

`ifdef RISCV_DX_MDU_DIV_EN
  logic [XLEN-1:0]   op_a;
  logic              bzero_q;
  logic [XLEN:0]     div_tmp, div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   div_q, div_r, div_res;
`endif

  // prod holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
    mul_next = {mul_sum, prod[XLEN-1:1]};
    mul_fin  = (a_neg_q ^ b_neg_q) ? -mul_next : mul_next;
    mul_res  = (f3_q[1:0] == 2'b00) ? mul_fin[XLEN-1:0] : mul_fin[2*XLEN-1:XLEN];
`ifdef RISCV_DX_MDU_DIV_EN
    div_tmp  = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
    div_diff = div_tmp - {1'b0, mcand};
    div_next = div_diff[XLEN] ? {div_tmp[XLEN-1:0], prod[XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], prod[XLEN-2:0], 1'b1};
    div_q    = div_next[XLEN-1:0];
    div_r    = div_next[2*XLEN-1:XLEN];
    if (bzero_q) begin
      div_q = '1;
      div_r = op_a;
    end else begin
      if (a_neg_q ^ b_neg_q) div_q = -div_q;
      if (a_neg_q) div_r = -div_r;
    end
    div_res    = f3_q[1] ? div_r : div_q;
    step_next  = f3_q[2] ? div_next : mul_next;
    fin_result = f3_q[2] ? div_res : mul_res;
`else
    step_next  = mul_next;
    fin_result = f3_q[2] ? '0 : mul_res;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dx_valid <= 1'b0;
      dx_inst  <= '0;
      dx_pc    <= RESET_PC;
    end else if (flush) begin
      dx_valid <= 1'b0;
    end else if (f_ready) begin
      dx_valid <= f_valid;
      if (f_valid) begin
        dx_inst <= f_inst;
        dx_pc   <= f_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      prod          <= '0;
      mcand         <= '0;
      f3_q          <= '0;
      a_neg_q       <= 1'b0;
      b_neg_q       <= 1'b0;
      dx_md_result  <= '0;
      dx_md_illegal <= 1'b0;
`ifdef RISCV_DX_MDU_DIV_EN
      op_a          <= '0;
      bzero_q       <= 1'b0;
`endif
    end else if (flush) begin
      state         <= S_IDLE;
      cnt           <= '0;
      dx_md_illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dx_valid && dx_is_md) begin
`ifndef RISCV_DX_MDU_DIV_EN
            if (f3_in[2]) begin
              state         <= S_DONE;
              dx_md_result  <= '0;
              dx_md_illegal <= 1'b1;
            end else
`endif
            begin
              state   <= S_BUSY;
              cnt     <= '0;
              prod    <= {{XLEN{1'b0}}, a_mag_in};
              mcand   <= b_mag_in;
              f3_q    <= f3_in;
              a_neg_q <= a_neg_in;
              b_neg_q <= b_neg_in;
`ifdef RISCV_DX_MDU_DIV_EN
              op_a    <= dx_rs1_fwd;
              bzero_q <= (dx_rs2_fwd == '0);
`endif
            end
          end
        end
        S_BUSY: begin
          prod <= step_next;
          if (cnt == CW'(XLEN - 1)) begin
            state        <= S_DONE;
            cnt          <= '0;
            dx_md_result <= fin_result;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (x_ready) begin
            state         <= S_IDLE;
            dx_md_illegal <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/riscv_dx_stage_mdu.md
Name: riscv_dx_stage_mdu

Overview:
Parametrised decode/execute pipeline stage for the RISC-V core. It registers the fetched instruction/PC with a valid/ready handshake and resolves operands from the regfile plus NUM_FWD prioritised forwarding sources. It also executes RV32M multiply ops on an iterative multi-cycle unit that back-pressures fetch. The ALU, branch compare and writeback stay outside this block and consume dx_rs1_fwd/dx_rs2_fwd.

Parameters:
XLEN, 32, datapath width
NUM_FWD, 2, number of forwarding sources; index 0 = youngest = highest priority
RESET_PC, 32'h2000, dx_pc reset value

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
f_valid  in  1  fetch presents instruction
f_inst  in  32  fetched instruction
f_pc  in  XLEN  fetched PC
f_ready  out  1  DX accepts f_* this cycle
flush  in  1  kill DX contents (taken branch/jump)
rf_rs1_data  in  XLEN  regfile read for dx_ra
rf_rs2_data  in  XLEN  regfile read for dx_rb
fwd_valid  in  NUM_FWD  forwarding source i valid
fwd_rd  in  5*NUM_FWD  forwarding dest reg, source i at [5i+4:5i]
fwd_data  in  XLEN*NUM_FWD  forwarding data, source i
dx_valid  out  1  DX register holds live instruction
dx_inst  out  32  registered instruction
dx_pc  out  XLEN  registered PC
dx_ra  out  5  dx_inst[19:15]
dx_rb  out  5  dx_inst[24:20]
dx_rs1_fwd  out  XLEN  resolved operand A
dx_rs2_fwd  out  XLEN  resolved operand B
dx_is_md  out  1  opcode 0110011 and funct7 0000001
dx_md_busy  out  1  MDU iterating
dx_md_result  out  XLEN  MDU result, valid while dx_out_valid && dx_is_md
dx_md_illegal  out  1  M-op not supported in this build
dx_out_valid  out  1  DX result available to X/MW
x_ready  in  1  downstream accepts

Behaviour:
- Reset, asynchronous on rst_n low: dx_valid=0, dx_inst=0, dx_pc=RESET_PC, MDU state IDLE, cnt=0, product/operand registers 0, dx_md_result=0, dx_md_illegal=0. Reset mid-MDU aborts the operation with no output.
- f_ready = !dx_valid || (dx_out_valid && x_ready).
- On a rising edge with f_ready && f_valid: load dx_inst/dx_pc and set dx_valid=1.
- On a rising edge with f_ready && !f_valid: dx_valid=0.
- flush has priority over everything: next cycle dx_valid=0, MDU returns to IDLE, and an f_* presented in the flush cycle is dropped.
- Operand resolution (combinational): if ra==0, output 0. Otherwise use the lowest i with fwd_valid[i] && fwd_rd[i]==ra, else rf_rs1_data. Operand B (rb) is resolved the same way.
- MDU FSM: IDLE, BUSY, DONE.
  - IDLE -> BUSY when dx_valid && dx_is_md && !flush. Latch the resolved operands and funct3, set cnt=0.
  - BUSY performs one shift-add step per cycle and increments cnt. When cnt==XLEN-1, apply the sign fix-up and go to DONE.
  - DONE -> IDLE when x_ready.
- MDU latency: instruction in DX at cycle T gives XLEN BUSY cycles and DONE at T+XLEN+1.
- dx_out_valid = dx_valid && (!dx_is_md || state==DONE). dx_md_busy = (state==BUSY).
- Multiply ops use a 2*XLEN product and operate on magnitudes. The product is negated when the operand signs differ, per signedness.
  - funct3 000 MUL: low XLEN bits.
  - funct3 001 MULH: high bits, signed x signed.
  - funct3 010 MULHSU: high bits, signed x unsigned.
  - funct3 011 MULHU: high bits, unsigned x unsigned.
- Back-pressure: while DONE && !x_ready, dx_md_result, dx_inst and dx_pc are held stable.
- Non-M instructions complete in 0 extra cycles. They are held only by !x_ready.

Optional Feature:
- Macro RISCV_DX_MDU_DIV_EN.
- With the macro defined: funct3 1xx runs restoring division, XLEN BUSY cycles, same latency as multiply.
  - 100 DIV and 101 DIVU give the quotient; 110 REM and 111 REMU give the remainder.
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Signed overflow (most-negative / -1): quotient = most-negative, remainder = 0.
- Without the macro: funct3 1xx skips BUSY, IDLE -> DONE next cycle, dx_md_result=0, dx_md_illegal=1 while in DONE.

Test Plan:
- MUL: rs1=7, rs2=0xFFFFFFFD -> dx_md_result=0xFFFFFFEB; dx_out_valid rises exactly 33 cycles after dx_valid; f_ready=0 meanwhile.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- Forwarding: ra=5, fwd0 and fwd1 both rd=5 with data 0x11/0x22 -> dx_rs1_fwd=0x11. Only fwd1 valid -> 0x22. ra=0 with fwd rd=0 valid -> 0.
- Flush asserted at BUSY cnt=10 -> next cycle IDLE, dx_valid=0, no dx_out_valid, f_ready=1. Flush together with f_valid -> instruction not loaded.
- Backpressure: x_ready=0 for 5 cycles in DONE -> result/dx_pc stable, f_ready=0. x_ready=1 -> new f_inst accepted the same edge.
- With RISCV_DX_MDU_DIV_EN: DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, DIVU 9/0 -> 0xFFFFFFFF, REMU 9/0 -> 9. Without the macro: DIV -> result 0, dx_md_illegal=1 one cycle after entry.
